// File: rtl/ifelse2_monitor_if.sv
// Control and result bus between ifelse2_monitor and its consumer:
// start/win_len launch a window, valid/ready hand back the statistics.
interface ifelse2_monitor_if #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
);
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic             ready;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] fall_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] max_run;

  modport master (
    output start, win_len, ready,
    input  busy, valid, rise_cnt, fall_cnt, high_cnt, max_run
  );

  modport slave (
    input  start, win_len, ready,
    output busy, valid, rise_cnt, fall_cnt, high_cnt, max_run
  );
endinterface

// File: rtl/ifelse2_monitor.sv
// Windowed activity monitor for the ifelse2 stage output y: counts edges,
// high cycles and the longest high run over N cycles, then offers the results.
module ifelse2_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y,
  ifelse2_monitor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic             y_q;
  logic             y_prev;
  logic [WIN_W-1:0] remaining;
  logic [CNT_W-1:0] rise_q;
  logic [CNT_W-1:0] fall_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] run_d;
  logic             load;
  logic             step;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start is only honoured in IDLE; a zero-length window skips RUN entirely
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = (bus.win_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (remaining == WIN_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign run_d = y_q ? sat_inc(run_q) : '0;

  // y_prev is preloaded with the first sample so a window never opens with an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= 1'b0;
      y_prev    <= 1'b0;
      remaining <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      high_q    <= '0;
      max_q     <= '0;
      run_q     <= '0;
    end else begin
      y_q <= y;
      if (load) begin
        remaining <= bus.win_len;
        y_prev    <= y;
        rise_q    <= '0;
        fall_q    <= '0;
        high_q    <= '0;
        max_q     <= '0;
        run_q     <= '0;
      end else if (step) begin
        remaining <= remaining - WIN_ONE;
        y_prev    <= y_q;
        run_q     <= run_d;
        if (y_q && !y_prev) begin
          rise_q <= sat_inc(rise_q);
        end
        if (!y_q && y_prev) begin
          fall_q <= sat_inc(fall_q);
        end
        if (y_q) begin
          high_q <= sat_inc(high_q);
        end
        if (run_d > max_q) begin
          max_q <= run_d;
        end
      end
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.valid    = (state_q == DONE);
  assign bus.rise_cnt = rise_q;
  assign bus.fall_cnt = fall_q;
  assign bus.high_cnt = high_q;
  assign bus.max_run  = max_q;

endmodule

// File: tb/tb_ifelse2_monitor.sv
// Bench for ifelse2_monitor: an 8-bit and a 4-bit counter instance run in lockstep
// on the same stimulus; the narrow one shows saturation on long windows.
module tb_ifelse2_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       y = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] win_len = 8'd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ifelse2_monitor_if #(.CNT_W(8), .WIN_W(8)) bus8 ();
  ifelse2_monitor_if #(.CNT_W(4), .WIN_W(8)) bus4 ();

  assign bus8.start   = start;
  assign bus8.win_len = win_len;
  assign bus8.ready   = ready;
  assign bus4.start   = start;
  assign bus4.win_len = win_len;
  assign bus4.ready   = ready;

  ifelse2_monitor #(.CNT_W(8), .WIN_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .y     (y),
    .bus   (bus8.slave)
  );

  ifelse2_monitor #(.CNT_W(4), .WIN_W(8)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .y     (y),
    .bus   (bus4.slave)
  );

  typedef struct {
    logic [15:0] pat;
    int          len;
    int          rise;
    int          fall;
    int          high;
    int          maxr;
  } vec_t;

  vec_t vecs[10];

  function automatic logic patBit(input logic [15:0] pat, input int idx);
    return (idx < 16) ? pat[idx] : pat[15];
  endfunction

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkResults(input string tag, input int rise, input int fall,
                              input int high, input int maxr);
    checkOutput({tag, " rise8"}, int'(bus8.rise_cnt), rise);
    checkOutput({tag, " fall8"}, int'(bus8.fall_cnt), fall);
    checkOutput({tag, " high8"}, int'(bus8.high_cnt), high);
    checkOutput({tag, " max8"},  int'(bus8.max_run),  maxr);
    checkOutput({tag, " rise4"}, int'(bus4.rise_cnt), sat4(rise));
    checkOutput({tag, " fall4"}, int'(bus4.fall_cnt), sat4(fall));
    checkOutput({tag, " high4"}, int'(bus4.high_cnt), sat4(high));
    checkOutput({tag, " max4"},  int'(bus4.max_run),  sat4(maxr));
  endtask

  // Launches one window with y[k] present at edge Ek, optionally poking start mid-run,
  // and returns busy-cycle count and edges from accept until valid is seen.
  task automatic applyStimulus(input logic [15:0] pat, input int len, input logic rdy,
                               input bit poke, output int busy_n, output int lat);
    int k;
    @(posedge clk); #1;
    ready   = rdy;
    start   = 1'b1;
    win_len = 8'(len);
    y       = pat[0];
    @(posedge clk); #1;
    start  = 1'b0;
    busy_n = 0;
    k      = 0;
    while (!bus8.valid && k < 400) begin
      if (bus8.busy) busy_n++;
      y = patBit(pat, k + 1);
      if (poke && k == 3) begin
        start   = 1'b1;
        win_len = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    lat   = k;
    checkOutput("valid_seen", int'(bus8.valid), 1);
    checkOutput("valid4_seen", int'(bus4.valid), 1);
  endtask

  initial begin
    int bn;
    int lat;

    vecs[0] = '{16'h0000, 10, 0, 0, 0, 0};
    vecs[1] = '{16'hFFFF, 10, 0, 0, 10, 10};
    vecs[2] = '{16'h0276, 10, 3, 2, 6, 3};
    vecs[3] = '{16'hFFFF, 0, 0, 0, 0, 0};
    vecs[4] = '{16'hFFFF, 1, 0, 0, 1, 1};
    vecs[5] = '{16'hFFFF, 255, 0, 0, 255, 255};
    vecs[6] = '{16'h5555, 8, 3, 4, 4, 1};
    vecs[7] = '{16'h00F0, 12, 1, 1, 4, 4};
    vecs[8] = '{16'h8000, 16, 1, 0, 1, 1};
    vecs[9] = '{16'h0003, 5, 0, 1, 2, 2};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", int'(bus8.busy), 0);
    checkOutput("reset valid", int'(bus8.valid), 0);
    checkResults("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].pat, vecs[i].len, 1'b1, 1'b0, bn, lat);
      checkOutput($sformatf("v%0d busy_cycles", i), bn, vecs[i].len);
      checkOutput($sformatf("v%0d latency", i), lat, vecs[i].len);
      checkResults($sformatf("v%0d", i), vecs[i].rise, vecs[i].fall,
                   vecs[i].high, vecs[i].maxr);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d valid_drop", i), int'(bus8.valid), 0);
      checkOutput($sformatf("v%0d persist", i), int'(bus8.high_cnt), vecs[i].high);
    end

    // Consumer stalls in DONE while start is poked in RUN and in DONE
    applyStimulus(16'h0276, 10, 1'b0, 1'b1, bn, lat);
    checkOutput("hs busy_cycles", bn, 10);
    checkOutput("hs latency", lat, 10);
    checkResults("hs", 3, 2, 6, 3);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start   = 1'b1;
        win_len = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput($sformatf("hs hold%0d valid", k), int'(bus8.valid), 1);
      checkOutput($sformatf("hs hold%0d rise", k), int'(bus8.rise_cnt), 3);
      checkOutput($sformatf("hs hold%0d max", k), int'(bus8.max_run), 3);
    end
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("hs accept valid", int'(bus8.valid), 0);
    checkOutput("hs accept busy", int'(bus8.busy), 0);
    checkResults("hs accept", 3, 2, 6, 3);
    @(posedge clk); #1;
    checkOutput("hs idle busy", int'(bus8.busy), 0);
    checkOutput("hs idle valid", int'(bus8.valid), 0);

    // Asynchronous reset in the middle of a running window
    @(posedge clk); #1;
    start   = 1'b1;
    win_len = 8'd10;
    y       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midrun busy", int'(bus8.busy), 1);
    checkOutput("midrun high", int'(bus8.high_cnt), 4);
    rst_n = 1'b0;
    #1;
    checkOutput("arst busy", int'(bus8.busy), 0);
    checkOutput("arst valid", int'(bus8.valid), 0);
    checkResults("arst", 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post-reset busy", int'(bus8.busy), 0);
    checkOutput("post-reset valid", int'(bus8.valid), 0);
    checkOutput("post-reset high", int'(bus8.high_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
